// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the registered sequential ALU.
//   - opcode constants OP_ADD .. OP_MUL (3-bit opcode space)
//   - state_t: controller states IDLE / MUL / DONE
//   - FLAG_* : bit positions inside the {N,Z,C,V} flags vector
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: unsigned shift-add multiplier, one partial-product step per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (discards any product in flight)
//   start      : load a (multiplicand) and b (multiplier); ignored while busy is high
//   a, b       : WIDTH-bit unsigned operands
//   busy       : a multiplication is stepping
//   done       : high during the cycle of the final step; product is complete after that edge
//   product    : 2*WIDTH-bit result register
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // The low half of product starts as the multiplier and is shifted out one
  // bit per step; the high half accumulates the partial products.
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){product[0]}} & {1'b0, mcand});
  end

  assign busy = (count != '0);
  assign done = (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else if (start && !busy) begin
      mcand   <= a;
      product <= {{WIDTH{1'b0}}, b};
      count   <= CW'(WIDTH);
    end else if (busy) begin
      product <= {sum, product[WIDTH-1:1]};
      count   <= count - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes and a multi-cycle multiply.
// Optional feature: define SEQ_ALU_FLAGS_EN to add the 4-bit {N,Z,C,V} flags output.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operation handshake (a, b, cin, s sampled on transfer)
//   a, b, cin, s          : operands, carry/shift-in, 3-bit opcode
//   out_valid / out_ready : result handshake
//   alu_out, alu_out_hi   : result (low / high product half for MUL; hi=0 otherwise)
//   alu_cout              : carry-out or bit shifted out
//   flags                 : {N,Z,C,V} (only with SEQ_ALU_FLAGS_EN)
//   dbg_state             : controller state, for observation only
//
// Handshake: a transfer happens on any rising edge where valid && ready.
// valid never depends on ready; once out_valid is high the result registers
// hold until the edge where out_ready is also high. in_ready is high only in
// IDLE with the result slot free or being drained in the same cycle, so a
// result is consumed and a new operation accepted on the same edge.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             alu_cout,
`ifdef SEQ_ALU_FLAGS_EN
  output logic [3:0]       flags,
`endif
  output state_t           dbg_state
);

  state_t             state;
  logic               live;       // low until the first edge after reset release
  logic               accept;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     arith;
  logic [WIDTH-1:0]   res;
  logic               res_c;
`ifdef SEQ_ALU_FLAGS_EN
  logic               res_v;
`endif

  assign in_ready  = live && (state == IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && (s == OP_MUL)),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; arithmetic is WIDTH+1 bits so the top bit is the carry.
  always_comb begin
    arith = '0;
    res   = '0;
    res_c = 1'b0;
    case (s)
      OP_ADD: begin
        arith = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res   = arith[WIDTH-1:0];
        res_c = arith[WIDTH];
      end
      OP_SUB: begin
        arith = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
        res   = arith[WIDTH-1:0];
        res_c = arith[WIDTH];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res   = {a[WIDTH-2:0], cin};
        res_c = a[WIDTH-1];
      end
      OP_SHR: begin
        res   = {cin, a[WIDTH-1:1]};
        res_c = a[0];
      end
      default: ;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  // Signed overflow: operands (b inverted for SUB) share a sign the result lacks.
  always_comb begin
    res_v = 1'b0;
    if (s == OP_ADD)
      res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    else if (s == OP_SUB)
      res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      live       <= 1'b0;
      out_valid  <= 1'b0;
      alu_out    <= '0;
      alu_out_hi <= '0;
      alu_cout   <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      flags      <= '0;
`endif
    end else begin
      live <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (s == OP_MUL) begin
              state <= MUL;
            end else begin
              alu_out    <= res;
              alu_out_hi <= '0;
              alu_cout   <= res_c;
              out_valid  <= 1'b1;
`ifdef SEQ_ALU_FLAGS_EN
              flags[FLAG_N] <= res[WIDTH-1];
              flags[FLAG_Z] <= (res == '0);
              flags[FLAG_C] <= res_c;
              flags[FLAG_V] <= res_v;
`endif
            end
          end
        end
        MUL: begin
          if (mul_done) state <= DONE;
        end
        DONE: begin
          // Never overwrite an unconsumed result.
          if (!out_valid || out_ready) begin
            alu_out    <= mul_product[WIDTH-1:0];
            alu_out_hi <= mul_product[2*WIDTH-1:WIDTH];
            alu_cout   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= IDLE;
`ifdef SEQ_ALU_FLAGS_EN
            flags[FLAG_N] <= mul_product[2*WIDTH-1];
            flags[FLAG_Z] <= (mul_product == '0);
            flags[FLAG_C] <= 1'b0;
            flags[FLAG_V] <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=8). Define SEQ_ALU_FLAGS_EN
// to also check the flags output.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W  = 8;
  localparam int QW = 2*W + 5;   // {flags[3:0], cout, hi, lo}

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_out_hi;
  logic         alu_cout;
`ifdef SEQ_ALU_FLAGS_EN
  logic [3:0]   flags;
`endif
  state_t       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  bit rand_ready   = 0;

  logic [QW-1:0] exp_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .s          (s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .alu_cout   (alu_cout),
`ifdef SEQ_ALU_FLAGS_EN
    .flags      (flags),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic from the opcode definitions.
  function automatic logic [QW-1:0] model(input longint ia, input longint ib,
                                          input longint ic, input longint sel);
    longint m, half, lo, hi, cout, v, n, z, r, sa, sb, sr;
    logic [QW-1:0] e;
    m = longint'(1) << W;
    half = m / 2;
    lo = 0; hi = 0; cout = 0; v = 0;
    sa = (ia >= half) ? ia - m : ia;
    sb = (ib >= half) ? ib - m : ib;
    case (sel)
      0: begin
        r = ia + ib + ic; lo = r % m; cout = r / m;
        sr = sa + sb + ic; v = (sr >= half || sr < -half) ? 1 : 0;
      end
      1: begin
        r = ia + (m - 1 - ib) + ic; lo = r % m; cout = r / m;
        sr = sa - sb - 1 + ic; v = (sr >= half || sr < -half) ? 1 : 0;
      end
      2: lo = ia & ib;
      3: lo = ia | ib;
      4: lo = ia ^ ib;
      5: begin lo = (2 * ia + ic) % m; cout = ia / half; end
      6: begin lo = ic * half + ia / 2; cout = ia % 2; end
      default: begin r = ia * ib; lo = r % m; hi = r / m; end
    endcase
    n = (sel == 7) ? hi / half : lo / half;
    z = (lo == 0 && hi == 0) ? 1 : 0;
    e = '0;
    e[W-1:0]   = lo[W-1:0];
    e[2*W-1:W] = hi[W-1:0];
    e[2*W]     = cout[0];
    e[2*W+4]   = n[0];
    e[2*W+3]   = z[0];
    e[2*W+2]   = cout[0];
    e[2*W+1]   = v[0];
    return e;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest
  // expected entry; the entry retires on the transfer edge.
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        check("res_lo",   alu_out,    e[W-1:0]);
        check("res_hi",   alu_out_hi, e[2*W-1:W]);
        check("res_cout", alu_cout,   e[2*W]);
`ifdef SEQ_ALU_FLAGS_EN
        check("res_flags", flags, e[2*W+4:2*W+1]);
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Random backpressure, applied only while rand_ready is set.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; presents an op and returns at posedge+1 after the
  // accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tcin, input logic [2:0] ts, output int waited);
    logic acc;
    a = ta; b = tb; cin = tcin; s = ts; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 100) begin
        check("accept_timeout", waited, 0);
        break;
      end
    end
    if (waited <= 100) exp_q.push_back(model(longint'(ta), longint'(tb), longint'(tcin), longint'(ts)));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int bound;
    logic [2:0] rs;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; s = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_alu_out_hi", alu_out_hi, 0);
    check("rst_alu_cout", alu_cout, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef SEQ_ALU_FLAGS_EN
    check("rst_flags", flags, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("ready_after_rst", in_ready, 1);

    // ADD overflow case
    send(8'h80, 8'h80, 1'b0, OP_ADD, w);
    in_valid = 1'b0;
    check("add_latency", out_valid, 1);
    check("add_out", alu_out, 8'h00);
    check("add_cout", alu_cout, 1);
`ifdef SEQ_ALU_FLAGS_EN
    check("add_flags", flags, 4'b0111);
`endif
    // SUB with borrow, then SHR
    send(8'h05, 8'h07, 1'b1, OP_SUB, w);
    in_valid = 1'b0;
    check("sub_out", alu_out, 8'hFE);
    check("sub_cout", alu_cout, 0);
`ifdef SEQ_ALU_FLAGS_EN
    check("sub_flags", flags, 4'b1000);
`endif
    send(8'h81, 8'h00, 1'b1, OP_SHR, w);
    in_valid = 1'b0;
    check("shr_out", alu_out, 8'hC0);
    check("shr_cout", alu_cout, 1);

    // MUL latency
    send(8'hFF, 8'hFF, 1'b0, OP_MUL, w);
    in_valid = 1'b0;
    check("mul_ready_low", in_ready, 0);
    for (int i = 1; i <= W; i++) begin
      cycle();
      check("mul_ready_low", in_ready, 0);
      check("mul_valid_low", out_valid, 0);
    end
    cycle();
    check("mul_valid", out_valid, 1);
    check("mul_hi", alu_out_hi, 8'hFE);
    check("mul_lo", alu_out, 8'h01);
    check("mul_ready_back", in_ready, 1);
    cycle();

    // Backpressure
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, OP_ADD, w);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_out", alu_out, 8'h03);
      check("bp_ready", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    send(8'h5A, 8'h0F, 1'b0, OP_XOR, w);
    in_valid = 1'b0;
    check("bp_same_cycle", w, 0);
    check("bp_new_out", alu_out, 8'h55);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) begin
      rs = (i < 7) ? 3'(i) : OP_ADD;
      send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), rs, w);
      check("b2b_no_bubble", w, 0);
      check("b2b_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    cycle();

    // Random ops with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), w);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    bound = 0;
    while (exp_q.size() != 0 && bound < 200) begin
      cycle();
      bound++;
    end
    check("drain", exp_q.size(), 0);

    // Reset in the middle of a MUL
    send(8'h0F, 8'h11, 1'b0, OP_MUL, w);
    in_valid = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_alu_out", alu_out, 0);
    check("mrst_alu_out_hi", alu_out_hi, 0);
    check("mrst_alu_cout", alu_cout, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_state", dbg_state, IDLE);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("mrst_ready_back", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      check("mrst_no_stale", out_valid, 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
